// File: rtl/mux_scan_feeder_if.sv
// Bundle between the scan feeder and its neighbours: register write port, scan
// control/handshake, and the mux-facing data/select outputs.
interface mux_scan_feeder_if #(
    parameter int WIDTH = 4
);
    logic             WrEn;
    logic [1:0]       WrAddr;
    logic [WIDTH-1:0] WrData;
    logic             Start;
    logic             Ready;
    logic [WIDTH-1:0] D0;
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] D2;
    logic [WIDTH-1:0] D3;
    logic [1:0]       S;
    logic             Valid;
    logic             Busy;
    logic             Done;
    logic             WrErr;

    modport master (
        input  WrEn, WrAddr, WrData, Start, Ready,
        output D0, D1, D2, D3, S, Valid, Busy, Done, WrErr
    );

    modport slave (
        output WrEn, WrAddr, WrData, Start, Ready,
        input  D0, D1, D2, D3, S, Valid, Busy, Done, WrErr
    );
endinterface

// File: rtl/mux_scan_feeder.sv
// Feeds a 4x1 mux: four writable data registers plus a select sequencer that walks
// S through 0..3 under Valid/Ready. Define MUX_SCAN_FEEDER_LOOP_EN to add a Loop input.
module mux_scan_feeder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic Clk,
    input  logic Reset_n,
`ifdef MUX_SCAN_FEEDER_LOOP_EN
    input  logic Loop,
`endif
    mux_scan_feeder_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] LAST_SEL = 2'(DEPTH - 1);

    state_t     state_reg;
    logic [1:0] s_reg;
    logic       valid_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       wrerr_reg;
    logic       wr_ok;
    logic       loop_sel;

    logic [WIDTH-1:0] data_all [DEPTH];

`ifdef MUX_SCAN_FEEDER_LOOP_EN
    assign loop_sel = Loop;
`else
    assign loop_sel = 1'b0;
`endif

    // Writes only land while idle, so the mux data never changes under a scan.
    assign wr_ok = (state_reg == IDLE) && bus.WrEn;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        logic [WIDTH-1:0] q_reg;

        always_ff @(posedge Clk) begin
            if (!Reset_n) begin
                q_reg <= '0;
            end else if (wr_ok && (bus.WrAddr == 2'(gi))) begin
                q_reg <= bus.WrData;
            end
        end

        assign data_all[gi] = q_reg;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
            s_reg     <= 2'd0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            wrerr_reg <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            wrerr_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    s_reg <= 2'd0;
                    if (bus.Start) begin
                        state_reg <= SCAN;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (bus.WrEn) begin
                        wrerr_reg <= 1'b1;
                    end
                    if (bus.Ready) begin
                        if (s_reg != LAST_SEL) begin
                            s_reg <= s_reg + 2'd1;
                        end else if (loop_sel) begin
                            s_reg <= 2'd0;
                        end else begin
                            // Done is asserted for exactly the one cycle spent in DONE.
                            s_reg     <= 2'd0;
                            state_reg <= DONE;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.WrEn) begin
                        wrerr_reg <= 1'b1;
                    end
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    s_reg     <= 2'd0;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.D0    = data_all[0];
    assign bus.D1    = data_all[1];
    assign bus.D2    = data_all[2];
    assign bus.D3    = data_all[3];
    assign bus.S     = s_reg;
    assign bus.Valid = valid_reg;
    assign bus.Busy  = busy_reg;
    assign bus.Done  = done_reg;
    assign bus.WrErr = wrerr_reg;
endmodule

// File: tb/tb_mux_scan_feeder.sv
// Directed vector table for mux_scan_feeder plus hand-written handshake/loop sequences.
module tb_mux_scan_feeder;
    logic Clk;
    logic Reset_n;
`ifdef MUX_SCAN_FEEDER_LOOP_EN
    logic Loop;
`endif

    mux_scan_feeder_if #(.WIDTH(4)) bus ();

    mux_scan_feeder #(.WIDTH(4), .DEPTH(4)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
`ifdef MUX_SCAN_FEEDER_LOOP_EN
        .Loop    (Loop),
`endif
        .bus     (bus.master)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst_n;
        logic        wren;
        logic [1:0]  wraddr;
        logic [3:0]  wrdata;
        logic        start;
        logic        ready;
        logic [15:0] d;      // {D3,D2,D1,D0}
        logic [1:0]  s;
        logic        valid;
        logic        busy;
        logic        done;
        logic        wrerr;
        logic [3:0]  mux;    // checked only when valid
    } vec_t;

    localparam int NVEC = 33;
    vec_t vecs [NVEC];

    int applied = 0;
    int miscompares = 0;

    function automatic vec_t mk(logic rst_n, logic wren, logic [1:0] wraddr, logic [3:0] wrdata,
                                logic start, logic ready, logic [15:0] d, logic [1:0] s,
                                logic valid, logic busy, logic done, logic wrerr, logic [3:0] mux);
        vec_t v;
        v.rst_n = rst_n; v.wren = wren; v.wraddr = wraddr; v.wrdata = wrdata;
        v.start = start; v.ready = ready; v.d = d; v.s = s; v.valid = valid;
        v.busy = busy; v.done = done; v.wrerr = wrerr; v.mux = mux;
        return v;
    endfunction

    function automatic logic [3:0] mux_of(logic [15:0] d, logic [1:0] s);
        logic [3:0] r;
        case (s)
            2'd0: r = d[3:0];
            2'd1: r = d[7:4];
            2'd2: r = d[11:8];
            default: r = d[15:12];
        endcase
        return r;
    endfunction

    function automatic logic [15:0] d_now();
        return {bus.D3, bus.D2, bus.D1, bus.D0};
    endfunction

    task automatic drive(logic rst_n, logic wren, logic [1:0] wraddr, logic [3:0] wrdata,
                         logic start, logic ready);
        Reset_n    = rst_n;
        bus.WrEn   = wren;
        bus.WrAddr = wraddr;
        bus.WrData = wrdata;
        bus.Start  = start;
        bus.Ready  = ready;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_bit(string name, logic act, logic exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        applied++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // rst wen a  dat  st rdy  D          S  V  B  Dn Er mux
        vecs[0]  = mk(0, 0, 0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 4'h0);
        vecs[1]  = mk(1, 1, 0, 4'hA, 0, 0, 16'h000A, 0, 0, 0, 0, 0, 4'h0);
        vecs[2]  = mk(1, 1, 1, 4'h5, 0, 0, 16'h005A, 0, 0, 0, 0, 0, 4'h0);
        vecs[3]  = mk(1, 1, 2, 4'hC, 0, 0, 16'h0C5A, 0, 0, 0, 0, 0, 4'h0);
        vecs[4]  = mk(1, 1, 3, 4'h3, 0, 0, 16'h3C5A, 0, 0, 0, 0, 0, 4'h0);
        vecs[5]  = mk(1, 0, 0, 4'h0, 1, 1, 16'h3C5A, 0, 1, 1, 0, 0, 4'hA);
        vecs[6]  = mk(1, 0, 0, 4'h0, 0, 1, 16'h3C5A, 1, 1, 1, 0, 0, 4'h5);
        vecs[7]  = mk(1, 0, 0, 4'h0, 0, 1, 16'h3C5A, 2, 1, 1, 0, 0, 4'hC);
        vecs[8]  = mk(1, 0, 0, 4'h0, 0, 1, 16'h3C5A, 3, 1, 1, 0, 0, 4'h3);
        vecs[9]  = mk(1, 0, 0, 4'h0, 0, 1, 16'h3C5A, 0, 0, 1, 1, 0, 4'h0);
        vecs[10] = mk(1, 0, 0, 4'h0, 0, 0, 16'h3C5A, 0, 0, 0, 0, 0, 4'h0);
        // Ready pattern 1,0,0,1,1,0,1 while Valid
        vecs[11] = mk(1, 0, 0, 4'h0, 1, 0, 16'h3C5A, 0, 1, 1, 0, 0, 4'hA);
        vecs[12] = mk(1, 0, 0, 4'h0, 0, 1, 16'h3C5A, 1, 1, 1, 0, 0, 4'h5);
        vecs[13] = mk(1, 0, 0, 4'h0, 0, 0, 16'h3C5A, 1, 1, 1, 0, 0, 4'h5);
        vecs[14] = mk(1, 0, 0, 4'h0, 0, 0, 16'h3C5A, 1, 1, 1, 0, 0, 4'h5);
        vecs[15] = mk(1, 0, 0, 4'h0, 0, 1, 16'h3C5A, 2, 1, 1, 0, 0, 4'hC);
        vecs[16] = mk(1, 0, 0, 4'h0, 0, 1, 16'h3C5A, 3, 1, 1, 0, 0, 4'h3);
        vecs[17] = mk(1, 0, 0, 4'h0, 0, 0, 16'h3C5A, 3, 1, 1, 0, 0, 4'h3);
        vecs[18] = mk(1, 0, 0, 4'h0, 1, 1, 16'h3C5A, 0, 0, 1, 1, 0, 4'h0);
        vecs[19] = mk(1, 0, 0, 4'h0, 0, 0, 16'h3C5A, 0, 0, 0, 0, 0, 4'h0);
        // Rejected write and ignored Start mid-scan, then reset at S=2
        vecs[20] = mk(1, 0, 0, 4'h0, 1, 0, 16'h3C5A, 0, 1, 1, 0, 0, 4'hA);
        vecs[21] = mk(1, 1, 2, 4'hF, 0, 1, 16'h3C5A, 1, 1, 1, 0, 1, 4'h5);
        vecs[22] = mk(1, 0, 0, 4'h0, 1, 1, 16'h3C5A, 2, 1, 1, 0, 0, 4'hC);
        vecs[23] = mk(1, 0, 0, 4'h0, 0, 0, 16'h3C5A, 2, 1, 1, 0, 0, 4'hC);
        vecs[24] = mk(0, 0, 0, 4'h0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 4'h0);
        // Start + write together; writes during DONE rejected
        vecs[25] = mk(1, 1, 0, 4'h7, 1, 0, 16'h0007, 0, 1, 1, 0, 0, 4'h7);
        vecs[26] = mk(1, 0, 0, 4'h0, 0, 1, 16'h0007, 1, 1, 1, 0, 0, 4'h0);
        vecs[27] = mk(1, 0, 0, 4'h0, 0, 1, 16'h0007, 2, 1, 1, 0, 0, 4'h0);
        vecs[28] = mk(1, 0, 0, 4'h0, 0, 1, 16'h0007, 3, 1, 1, 0, 0, 4'h0);
        vecs[29] = mk(1, 1, 1, 4'h9, 0, 1, 16'h0007, 0, 0, 1, 1, 1, 4'h0);
        vecs[30] = mk(1, 1, 1, 4'h9, 1, 0, 16'h0007, 0, 0, 0, 0, 1, 4'h0);
        vecs[31] = mk(1, 0, 0, 4'h0, 0, 1, 16'h0007, 0, 0, 0, 0, 0, 4'h0);
        vecs[32] = mk(1, 1, 3, 4'hE, 0, 0, 16'hE007, 0, 0, 0, 0, 0, 4'h0);

`ifdef MUX_SCAN_FEEDER_LOOP_EN
        Loop = 1'b0;
`endif
        drive(0, 0, 0, 4'h0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            logic ok;
            logic [15:0] d_act;
            drive(vecs[i].rst_n, vecs[i].wren, vecs[i].wraddr, vecs[i].wrdata,
                  vecs[i].start, vecs[i].ready);
            tick();
            d_act = d_now();
            ok = (d_act === vecs[i].d) && (bus.S === vecs[i].s) &&
                 (bus.Valid === vecs[i].valid) && (bus.Busy === vecs[i].busy) &&
                 (bus.Done === vecs[i].done) && (bus.WrErr === vecs[i].wrerr) &&
                 (!vecs[i].valid || (mux_of(d_act, bus.S) === vecs[i].mux));
            applied++;
            if (!ok) begin
                miscompares++;
                $display("FAIL vec%0d: got D=%h S=%0d V=%b B=%b Done=%b WrErr=%b mux=%h expected D=%h S=%0d V=%b B=%b Done=%b WrErr=%b mux=%h",
                         i, d_act, bus.S, bus.Valid, bus.Busy, bus.Done, bus.WrErr,
                         mux_of(d_act, bus.S), vecs[i].d, vecs[i].s, vecs[i].valid,
                         vecs[i].busy, vecs[i].done, vecs[i].wrerr, vecs[i].mux);
            end else begin
                $display("vec%0d: D=%h S=%0d V=%b B=%b Done=%b WrErr=%b ok",
                         i, d_act, bus.S, bus.Valid, bus.Busy, bus.Done, bus.WrErr);
            end
        end

        // Irregular Ready: count transfers and Done pulses over one full scan
        begin
            logic [11:0] rdy_pat;
            logic [3:0]  seen [4];
            int          xfers;
            int          dones;
            int          order_bad;
            int          cyc;
            rdy_pat   = 12'b1010_0110_1101;
            xfers     = 0;
            dones     = 0;
            order_bad = 0;
            cyc       = 0;
            drive(1, 0, 0, 4'h0, 1, 0);
            tick();
            drive(1, 0, 0, 4'h0, 0, 0);
            while ((bus.Busy || cyc == 0) && cyc < 40) begin
                bus.Ready = rdy_pat[cyc % 12];
                if (bus.Valid && bus.Ready) begin
                    if (xfers < 4) seen[xfers] = mux_of(d_now(), bus.S);
                    if (int'(bus.S) != xfers) order_bad++;
                    xfers++;
                end
                tick();
                if (bus.Done) dones++;
                cyc++;
            end
            check_int("hs_cycle_budget", (cyc < 40) ? 1 : 0, 1);
            check_int("hs_transfers", xfers, 4);
            check_int("hs_done_pulses", dones, 1);
            check_int("hs_order", order_bad, 0);
            check_int("hs_entry0", int'(seen[0]), 7);
            check_int("hs_entry3", int'(seen[3]), 14);
            $display("handshake scan: %0d transfers, %0d done pulses in %0d cycles", xfers, dones, cyc);
        end

`ifdef MUX_SCAN_FEEDER_LOOP_EN
        // Loop held high: S keeps cycling with no Done; drop Loop before the S==3 transfer
        begin
            int done_seen;
            done_seen = 0;
            drive(1, 0, 0, 4'h0, 1, 1);
            Loop = 1'b1;
            tick();
            drive(1, 0, 0, 4'h0, 0, 1);
            for (int k = 1; k <= 7; k++) begin
                tick();
                if (bus.Done) done_seen++;
                check_int("loop_s", int'(bus.S), k % 4);
                check_bit("loop_valid", bus.Valid, 1'b1);
                $display("loop step %0d: S=%0d V=%b", k, bus.S, bus.Valid);
            end
            check_int("loop_no_done", done_seen, 0);
            Loop = 1'b0;
            tick();
            check_bit("loop_exit_done", bus.Done, 1'b1);
            check_bit("loop_exit_valid", bus.Valid, 1'b0);
            tick();
            check_bit("loop_exit_idle", bus.Busy, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

// File: doc/mux_scan_feeder.md
Name: mux_scan_feeder

Overview:
- Upstream feeder for the 4-bit 4x1 multiplexer stage.
- Holds four 4-bit data registers that drive the mux data inputs D0..D3, plus a 2-bit select sequencer that drives the mux select S.
- On a Start pulse it steps S through 0,1,2,3 under a Valid/Ready handshake, so the downstream consumer sees each register in turn on the mux output.
- Software-style write port loads the registers while the block is idle.

Parameters:
- WIDTH, 4, data register width; must match the mux data width. Only 4 is supported.
- DEPTH, 4, number of registers/select codes. Fixed by the 2-bit select; only 4 is supported.

Ports:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  synchronous active-low reset, sampled on the Clk rising edge
- WrEn  input  1  register write strobe
- WrAddr  input  2  register index to write
- WrData  input  4  write data
- Start  input  1  single-cycle request to begin a scan
- Ready  input  1  downstream accepts the current selection
- D0, D1, D2, D3  output  4 each  register contents, wired to the mux data inputs
- S  output  2  mux select
- Valid  output  1  S/D outputs present a valid selection
- Busy  output  1  scan in progress (SCAN or DONE state)
- Done  output  1  one-cycle pulse after the last entry is accepted
- WrErr  output  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - D0..D3=0, S=0, Valid=0, Busy=0, Done=0, WrErr=0, state=IDLE.
  - Reset overrides everything, including a scan in progress: the next cycle is IDLE with registers cleared.
- All outputs are registered. No combinational path from any input to any output.
- States:
  - IDLE: Valid=0, Busy=0, S held at 0.
    - Start=1 -> SCAN with S=0.
    - WrEn=1 -> register[WrAddr] <= WrData. The new value is visible on Dn the next cycle.
    - Start and WrEn in the same cycle: both take effect. Entry 0 of the scan shows the new data.
  - SCAN: Valid=1, Busy=1.
    - Ready=1 and S<3 -> S<=S+1.
    - Ready=1 and S==3 -> DONE. S wraps to 0; Valid drops on the next cycle.
    - Ready=0 -> S and D0..D3 hold stable (handshake hold rule).
    - Start is ignored.
    - WrEn=1 -> write is discarded, registers unchanged, WrErr=1 for the next cycle.
  - DONE: Valid=0, Busy=1, Done=1 for exactly this one cycle, then -> IDLE.
    - Start and WrEn behave as in SCAN: Start ignored, a write is rejected with WrErr.
- Latency:
  - Start at edge N -> Valid=1 with S=0 after edge N.
  - Scan with Ready held high: 4 Valid cycles, then 1 Done cycle.
  - Minimum Start-to-Start spacing is 6 cycles.
- Transfer: a transfer occurs on any edge with Valid=1 and Ready=1. Exactly 4 transfers per scan, in S order 0,1,2,3.
- Ready sampled while Valid=0 has no effect.

Optional Feature:
- Macro: MUX_SCAN_FEEDER_LOOP_EN
- Defined:
  - Adds input port Loop (1 bit).
  - In SCAN, if Ready=1, S==3 and Loop=1, S wraps to 0 and the block stays in SCAN with Valid=1. No Done pulse is issued.
  - Loop is sampled only at that transfer. Loop=0 there takes the normal DONE path.
- Not defined: the Loop port is absent and every scan ends after 4 transfers.

Test Plan:
- Reset, then write 4'hA, 4'h5, 4'hC, 4'h3 to addresses 0..3 -> D0..D3 = A,5,C,3; Valid=0, S=0, Busy=0.
- Start with Ready=1 -> S=0,1,2,3 on 4 consecutive cycles with Valid=1; mux output A,5,C,3; then Done=1 for 1 cycle; Busy low after 5 cycles.
- Start with Ready pattern 1,0,0,1,1,0,1 -> S=0 transferred; S=1 held stable through both Ready=0 cycles (D unchanged); 4 transfers total; Done pulses exactly once.
- WrEn to address 2 with 4'hF during SCAN -> WrErr=1 next cycle, D2 stays 4'hC. Start asserted mid-scan does not restart (S continues).
- Reset_n=0 while S=2 in SCAN -> next cycle: Valid=0, Busy=0, S=0, D0..D3=0, Done=0.
- With MUX_SCAN_FEEDER_LOOP_EN, Loop=1, Ready=1 -> S cycles 0..3,0..3 continuously with no Done. Dropping Loop before the S==3 transfer -> Done one cycle after that transfer.
